// File: rtl/tt_alu_seq.sv
// ============================================================================
// tt_alu_seq : sequential ALU, shared operand bus, start/busy/done handshake.
// Optional iterative shift-add multiplier enabled by macro ALU_MUL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tt_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [2:0]       op_sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_wa, r_wb;
  logic [2:0]       r_op;
  logic             r_c;
  logic [SHW-1:0]   r_cnt, w_cnt_init;
  logic             w_accept, w_last;

  logic [WIDTH-1:0] w_wa_nxt, w_wb_nxt, w_res, w_res_hi;
  logic             w_c_nxt, w_v, w_c, w_z;
  logic [WIDTH:0]   w_sum, w_dif;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH:0]   w_macc;
`endif

  assign w_accept = start && (r_state != S_EXEC);
  assign w_last   = (r_state == S_EXEC) && (r_cnt == '0);

  // Counter holds N-1 so the FSM leaves EXEC after exactly N cycles.
  always_comb begin
    w_cnt_init = '0;
    case (op_sel)
      OP_SHL, OP_SHR: w_cnt_init = (r_b[SHW-1:0] == '0) ? '0 : r_b[SHW-1:0] - 1'b1;
`ifdef ALU_MUL_EN
      OP_MUL:         w_cnt_init = SHW'(WIDTH - 1);
`endif
      default:        w_cnt_init = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_EXEC : S_IDLE;
      S_EXEC:  w_state_nxt = (r_cnt == '0) ? S_DONE : S_EXEC;
      S_DONE:  w_state_nxt = start ? S_EXEC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_EXEC);
    done = (r_state == S_DONE);
  end

  // One EXEC step: next working state plus the value to publish if it is the last.
  always_comb begin
    w_wa_nxt = r_wa;
    w_wb_nxt = r_wb;
    w_c_nxt  = r_c;
    w_res    = '0;
    w_res_hi = '0;
    w_v      = 1'b0;
    w_c      = 1'b0;
    w_sum    = {1'b0, r_wa} + {1'b0, r_wb};
    w_dif    = {1'b0, r_wa} - {1'b0, r_wb};
`ifdef ALU_MUL_EN
    w_hi_nxt = r_hi;
    w_macc   = {1'b0, r_hi} + (r_wb[0] ? {1'b0, r_wa} : {(WIDTH+1){1'b0}});
`endif
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_wa[WIDTH-1] == r_wb[WIDTH-1]) && (w_sum[WIDTH-1] != r_wa[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (r_wa[WIDTH-1] != r_wb[WIDTH-1]) && (w_dif[WIDTH-1] != r_wa[WIDTH-1]);
      end
      OP_AND: w_res = r_wa & r_wb;
      OP_OR:  w_res = r_wa | r_wb;
      OP_XOR: w_res = r_wa ^ r_wb;
      OP_SHL: begin
        if (r_wb[SHW-1:0] != '0) begin
          w_wa_nxt = {r_wa[WIDTH-2:0], 1'b0};
          w_c_nxt  = r_wa[WIDTH-1];
        end
        w_res = w_wa_nxt;
        w_c   = w_c_nxt;
      end
      OP_SHR: begin
        if (r_wb[SHW-1:0] != '0) begin
          w_wa_nxt = {1'b0, r_wa[WIDTH-1:1]};
          w_c_nxt  = r_wa[0];
        end
        w_res = w_wa_nxt;
        w_c   = w_c_nxt;
      end
      default: begin
`ifdef ALU_MUL_EN
        // {hi, wb} is the product/multiplier pair, shifted right each step.
        w_hi_nxt = w_macc[WIDTH:1];
        w_wb_nxt = {w_macc[0], r_wb[WIDTH-1:1]};
        w_res    = w_wb_nxt;
        w_res_hi = w_hi_nxt;
        w_c      = |w_hi_nxt;
`else
        w_v      = 1'b1;
`endif
      end
    endcase
    w_z = (w_res == '0) && (w_res_hi == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_wa      <= '0;
      r_wb      <= '0;
      r_op      <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
`ifdef ALU_MUL_EN
      r_hi      <= '0;
`endif
    end else begin
      if (r_state != S_EXEC) begin
        if (load_a) r_a <= operand_in;
        if (load_b) r_b <= operand_in;
      end
      if (w_last) begin
        result    <= w_res;
        result_hi <= w_res_hi;
        flags     <= {w_v, w_res[WIDTH-1], w_c, w_z};
      end
      if (w_accept) begin
        r_op  <= op_sel;
        r_wa  <= r_a;
        r_wb  <= r_b;
        r_c   <= 1'b0;
        r_cnt <= w_cnt_init;
`ifdef ALU_MUL_EN
        r_hi  <= '0;
`endif
      end else if (r_state == S_EXEC) begin
        r_wa  <= w_wa_nxt;
        r_wb  <= w_wb_nxt;
        r_c   <= w_c_nxt;
        r_cnt <= r_cnt - 1'b1;
`ifdef ALU_MUL_EN
        r_hi  <= w_hi_nxt;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/tt_alu_seq.md
Name: tt_alu_seq

Overview:
- Parametrised, sequential successor to the pin-driven 8-bit ALU wrapper.
- Operands are loaded into internal A/B registers over one shared bus.
- A start/busy/done handshake runs the operation. Single-cycle logic/arith ops, iterative shifts and an optional iterative shift-add multiplier are supported.
- Registered result and flags sit behind the Tiny Tapeout top-level pin mapping.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 4
SHW, $clog2(WIDTH), derived; shift-amount bits taken from B[SHW-1:0]

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
operand_in  input  WIDTH  shared operand bus
load_a  input  1  capture operand_in into A when busy=0
load_b  input  1  capture operand_in into B when busy=0
op_sel  input  3  opcode, sampled with start
start  input  1  begin operation when busy=0
busy  output  1  high while in EXEC
done  output  1  one-cycle pulse, result/flags valid and updated
result  output  WIDTH  low result word
result_hi  output  WIDTH  high product word (MUL only, else 0)
flags  output  4  {V,N,C,Z}

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - A, B, result, result_hi, flags, busy and done all become 0.
  - Reset during EXEC aborts the operation; no done pulse follows.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: busy=0, done=0.
  - EXEC: busy=1. The iteration counter runs N cycles, then the FSM goes to DONE.
  - DONE: lasts 1 cycle, done=1, busy=0. Next state is EXEC if start=1, else IDLE.
- start is accepted in IDLE or DONE. On accept, op_sel, A and B are copied into working registers.
  - start with busy=1 is ignored.
- Latency:
  - start sampled at edge k gives EXEC in cycles k+1..k+N.
  - done is high in cycle k+N+1.
  - result and flags update on the edge that enters DONE and hold until the next DONE.
- N per opcode:
  - 1 for 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR.
  - max(1, B[SHW-1:0]) for 101 SHL and 110 SHR (logical, one bit per cycle).
  - WIDTH for 111 MUL.
- load_a/load_b:
  - Honoured only when busy=0; ignored in EXEC.
  - If load_a and load_b are both asserted, both registers take operand_in.
  - Load and start in the same cycle: the operation uses the pre-edge A/B; the loaded value applies to the next operation.
- Arithmetic: all operations are unsigned, mod 2^WIDTH.
- result_hi is 0 for every op except MUL.
- Z flag:
  - Z = (result==0).
  - For MUL, Z = ({result_hi,result}==0).
- N flag: N = result[WIDTH-1].
- C flag:
  - ADD: carry out.
  - SUB: borrow (1 iff A<B).
  - SHL/SHR: last bit shifted out; 0 when the shift amount is 0.
  - MUL: (result_hi != 0).
  - Logic ops: 0.
- V flag:
  - Signed overflow for ADD/SUB.
  - 0 otherwise, except for the illegal MUL opcode (see below).
- Shift by 0: one EXEC cycle, result=A, C=0.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - Opcode 111 performs an iterative shift-add multiply over WIDTH EXEC cycles.
  - The full 2*WIDTH product appears on {result_hi,result}.
- Undefined:
  - No multiplier datapath is built.
  - Opcode 111 takes 1 EXEC cycle and gives result=0, result_hi=0, flags={V=1,N=0,C=0,Z=1}. V=1 marks the illegal opcode.

Test Plan:
- WIDTH=8; load A=0xFF, B=0x01; start ADD at edge k -> busy=1 in cycle k+1; done in k+2; result=0x00, flags V=0 N=0 C=1 Z=1.
- Load A=0x80, B=0x01; SUB -> result=0x7F, V=1, N=0, C=0, Z=0; done 2 cycles after start.
- Load A=0x81, B=0x03; SHL -> busy for 3 cycles; done at k+4; result=0x08, C=0.
- Same operands with SHR -> result=0x10, C=0.
- ALU_MUL_EN defined; A=0xFF, B=0xFF; MUL -> done at k+9; result_hi=0xFE, result=0x01, C=1.
- ALU_MUL_EN undefined; same stimulus -> done at k+2; result=0, V=1, Z=1.
- During MUL EXEC: pulse load_a with 0x55 and start -> both ignored; product unchanged; A still 0xFF afterwards.
- Assert rst in the 4th EXEC cycle -> next cycle busy=0, result=0, flags=0; no done pulse afterwards.
- Back-to-back: start asserted in the DONE cycle of an ADD -> new EXEC next cycle; busy never low between; done pulses once per op.
